// File: rtl/sam_video_pkg.sv
// sam_video_pkg
// Shared definitions for the SAM video fetch path. It provides the line-fetcher
// FSM states, the screen geometry constants and the helper that builds a
// linear mode 3/4 VRAM address.
// Ports: none (package).
package sam_video_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    localparam int SCREEN_LINES      = 192;
    localparam int MODE34_LINE_BYTES = 128;
    localparam int VRAM_ADDR_W       = 19;

    // Screen pages come in pairs, so bit 0 of the page number does not take
    // part in the address. A mode 3/4 line is 128 linear bytes.
    function automatic logic [VRAM_ADDR_W-1:0] line_addr(
        input logic [4:0] page,
        input logic [7:0] line,
        input logic [6:0] col
    );
        return {page[4:1], line, col};
    endfunction

endpackage

// File: rtl/sam_sync_fifo.sv
// sam_sync_fifo
// Show-ahead synchronous FIFO. The head entry is always presented on
// pop_data, which reads as zero when the FIFO is empty. A push and a pop in
// the same cycle are allowed even when the FIFO is full, because the pop
// frees the slot that the push fills. The flush input empties the FIFO in one
// cycle and takes priority over push and pop.
// Ports:
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous reset, active-high
//   flush      in   1      discard all contents
//   push       in   1      write push_data
//   push_data  in   WIDTH  write data
//   pop        in   1      advance the head (ignored when empty)
//   pop_data   out  WIDTH  head entry, zero when empty
//   empty      out  1      no entries
//   full       out  1      DEPTH entries
module sam_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // The pointers carry one extra wrap bit. When the low bits are equal,
    // that bit tells a full FIFO apart from an empty one.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update. Reset and flush both return the FIFO to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // The storage array has no reset. Entries are only read back after a push.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sam_vram_line_fetcher.sv
// sam_vram_line_fetcher
// Video-side client of the SRAM turn arbiter. On each line_start it latches
// the display line and screen page. During the ASIC's SRAM turns it then
// walks the 128 linear bytes of that mode 3/4 scanline. It captures one byte
// per turn into a show-ahead FIFO, which the pixel serialiser drains.
// Ports:
//   clk           in   1   clock, posedge
//   rst           in   1   synchronous reset, active-high
//   whichturn     in   1   1 = ASIC owns the SRAM this cycle
//   line_start    in   1   pulse: begin fetching a new line
//   line_num      in   8   display line, sampled on line_start
//   screen_page   in   5   screen page, sampled on line_start (bit 0 unused)
//   vramaddr      out  19  SRAM address for ASIC turns
//   data_to_asic  in   8   SRAM read data, valid while whichturn=1
//   pix_rd        in   1   pop request from the serialiser
//   pix_data      out  8   FIFO head, 8'h00 when empty
//   pix_valid     out  1   FIFO non-empty
//   line_done     out  1   pulse after the last byte of the line is pushed
//   underrun      out  1   sticky: pop attempted while empty
module sam_vram_line_fetcher
    import sam_video_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_DLY = 1,
    parameter int LINE_BYTES = MODE34_LINE_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        whichturn,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    input  logic [4:0]  screen_page,
    output logic [18:0] vramaddr,
    input  logic [7:0]  data_to_asic,
    input  logic        pix_rd,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        line_done,
    output logic        underrun
);

    // The turn counter saturates rather than wrapping. This means it passes
    // SAMPLE_DLY only once per turn, so a turn captures at most one byte.
    localparam int TC_W     = $clog2(SAMPLE_DLY + 2);
    localparam int LAST_COL = LINE_BYTES - 1;

    fetch_state_t state;
    fetch_state_t next_state;

    logic [TC_W-1:0] tc;
    logic [6:0]      col;
    logic [7:0]      line_q;
    logic [4:0]      page_q;
    logic            capture;
    logic            pop_ok;
    logic            push;
    logic            last_col;
    logic            fifo_empty;
    logic            fifo_full;

    assign capture  = whichturn && (tc == TC_W'(SAMPLE_DLY));
    assign pop_ok   = pix_rd && pix_valid;
    assign last_col = (col == 7'(LAST_COL));

    // Next-state logic and push decision. A line_start overrides any capture
    // in the same cycle, so the byte from that capture is dropped. When the
    // FIFO is full, a simultaneous pop frees the slot for the push.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (line_start) begin
                    next_state = FETCH;
                end else if (capture && (!fifo_full || pop_ok)) begin
                    push = 1'b1;
                    if (last_col) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (line_start) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Turn counter. It counts cycles since the ASIC turn began.
    always_ff @(posedge clk) begin
        if (rst || !whichturn) begin
            tc <= '0;
        end else if (tc != '1) begin
            tc <= tc + TC_W'(1);
        end
    end

    // Line context, column walk, address and status flags. The address is
    // registered from col, so it follows col one cycle later. The column
    // stops at the last byte and does not wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q    <= '0;
            page_q    <= '0;
            col       <= '0;
            vramaddr  <= '0;
            line_done <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            vramaddr  <= line_addr(page_q, line_q, col);
            line_done <= push && last_col;
            if (line_start) begin
                line_q   <= line_num;
                page_q   <= screen_page;
                col      <= '0;
                underrun <= 1'b0;
            end else begin
                if (push && !last_col) begin
                    col <= col + 7'd1;
                end
                if (pix_rd && !pix_valid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    sam_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (line_start),
        .push      (push),
        .push_data (data_to_asic),
        .pop       (pix_rd),
        .pop_data  (pix_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign pix_valid = !fifo_empty;

endmodule

// File: tb/tb_sam_vram_line_fetcher.sv
// tb_sam_vram_line_fetcher
// Bench for the line fetcher. A model SRAM returns a byte derived from the
// address. Each line_start loads a queue with the 128 bytes that line should
// deliver, and every pop is compared against the head of that queue.
module tb_sam_vram_line_fetcher;

    localparam int LINE = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        whichturn;
    logic        line_start;
    logic [7:0]  line_num;
    logic [4:0]  screen_page;
    logic [18:0] vramaddr;
    logic [7:0]  data_to_asic;
    logic        pix_rd;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        line_done;
    logic        underrun;

    logic        turn_auto;
    logic        manual_turn;
    logic        rd_auto;
    logic        manual_rd;
    logic [1:0]  phase = 2'd0;

    int tests_run    = 0;
    int tests_failed = 0;
    int ld_count     = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic [7:0]  line;
        logic [4:0]  page;
        logic [18:0] exp_first;
        logic [18:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [7:0] sram_byte(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    sam_vram_line_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .whichturn    (whichturn),
        .line_start   (line_start),
        .line_num     (line_num),
        .screen_page  (screen_page),
        .vramaddr     (vramaddr),
        .data_to_asic (data_to_asic),
        .pix_rd       (pix_rd),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .line_done    (line_done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Turn pattern 1100 repeating when automatic.
    always @(posedge clk) phase <= phase + 2'd1;

    assign whichturn    = turn_auto ? (phase < 2'd2) : manual_turn;
    assign pix_rd       = rd_auto | manual_rd;
    assign data_to_asic = whichturn ? sram_byte(vramaddr) : 8'hEE;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pop monitor and line_done counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && pix_rd && pix_valid) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL sb_underflow: got pop of 0x%0h, expected no byte", pix_data);
            end else begin
                checkOutput("pix_data", {24'd0, pix_data}, {24'd0, sb.pop_front()});
            end
        end
        if (line_done) ld_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise line_start so that the cycle after it is not a capture cycle.
    // Then load the expected bytes of the new line into the queue.
    task automatic startLine(input logic [7:0] ln, input logic [4:0] pg);
        logic [18:0] base;
        for (int k = 0; k < 4 && turn_auto && phase != 2'd2; k++) tick();
        line_num    = ln;
        screen_page = pg;
        line_start  = 1'b1;
        tick();
        line_start  = 1'b0;
        base = {pg[4:1], ln, 7'd0};
        sb.delete();
        for (int c = 0; c < LINE; c++) sb.push_back(sram_byte(base + 19'(c)));
    endtask

    // Wait for the end of the line, then drain the FIFO and check the totals.
    task automatic runToEnd(input string name, input logic [18:0] exp_last, input int ld_before);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (line_done) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({name, "_line_done_seen"}, {31'd0, ok}, 32'd1);
        checkOutput({name, "_last_addr"}, {13'd0, vramaddr}, {13'd0, exp_last});
        tick();
        checkOutput({name, "_line_done_pulse"}, {31'd0, line_done}, 32'd0);
        for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
        tick();
        checkOutput({name, "_sb_empty"}, sb.size(), 32'd0);
        checkOutput({name, "_drained"}, {31'd0, pix_valid}, 32'd0);
        checkOutput({name, "_line_done_count"}, ld_count, ld_before + 1);
        checkOutput({name, "_addr_held"}, {13'd0, vramaddr}, {13'd0, exp_last});
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int ldb;
        ldb = ld_count;
        startLine(v.line, v.page);
        tick();
        checkOutput($sformatf("vec%0d_first_addr", idx), {13'd0, vramaddr}, {13'd0, v.exp_first});
        runToEnd($sformatf("vec%0d", idx), v.exp_last, ldb);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [18:0] base;
        logic        found;
        int          ldb;

        vecs[0] = '{line: 8'd0,   page: 5'd3,  exp_first: 19'h08000, exp_last: 19'h0807F};
        vecs[1] = '{line: 8'd191, page: 5'd31, exp_first: 19'h7DF80, exp_last: 19'h7DFFF};
        vecs[2] = '{line: 8'd100, page: 5'd10, exp_first: 19'h2B200, exp_last: 19'h2B27F};
        vecs[3] = '{line: 8'd1,   page: 5'd2,  exp_first: 19'h08080, exp_last: 19'h080FF};

        rst = 1'b1; line_start = 1'b0; line_num = '0; screen_page = '0;
        turn_auto = 1'b1; manual_turn = 1'b0; rd_auto = 1'b0; manual_rd = 1'b0;
        tick(); tick();
        checkOutput("reset_vramaddr",  {13'd0, vramaddr}, 32'd0);
        checkOutput("reset_pix_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("reset_pix_data",  {24'd0, pix_data}, 32'd0);
        checkOutput("reset_line_done", {31'd0, line_done}, 32'd0);
        checkOutput("reset_underrun",  {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        tick();

        // Full lines with the serialiser popping every cycle.
        rd_auto = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

        // FIFO fills and stalls with no pops, then resumes.
        rd_auto = 1'b0;
        ldb = ld_count;
        base = 19'h18280;
        startLine(8'd5, 5'd6);
        for (int k = 0; k < 80; k++) tick();
        checkOutput("stall_valid", {31'd0, pix_valid}, 32'd1);
        checkOutput("stall_addr", {13'd0, vramaddr}, {13'd0, base + 19'd8});
        checkOutput("stall_head", {24'd0, pix_data}, {24'd0, sram_byte(base)});
        checkOutput("stall_no_done", ld_count, ldb);
        rd_auto = 1'b1;
        runToEnd("stall", base + 19'd127, ldb);

        // A one-cycle turn captures nothing. The next 2-cycle turn captures the same address.
        turn_auto = 1'b0; manual_turn = 1'b0;
        ldb = ld_count;
        base = 19'h20A00;
        startLine(8'd20, 5'd8);
        tick(); tick(); tick();
        manual_turn = 1'b1; tick();
        manual_turn = 1'b0; tick(); tick(); tick();
        checkOutput("short_turn_addr", {13'd0, vramaddr}, {13'd0, base});
        checkOutput("short_turn_valid", {31'd0, pix_valid}, 32'd0);
        manual_turn = 1'b1; tick(); tick();
        manual_turn = 1'b0;
        checkOutput("retry_valid", {31'd0, pix_valid}, 32'd1);
        checkOutput("retry_data", {24'd0, pix_data}, {24'd0, sram_byte(base)});
        tick();
        checkOutput("retry_addr_next", {13'd0, vramaddr}, {13'd0, base + 19'd1});
        manual_turn = 1'b1; tick(); tick(); tick();
        manual_turn = 1'b0; tick(); tick(); tick();
        checkOutput("long_turn_one_capture", {13'd0, vramaddr}, {13'd0, base + 19'd2});
        turn_auto = 1'b1;
        runToEnd("turns", base + 19'd127, ldb);

        // A line_start in mid-fetch aborts the current line.
        ldb = ld_count;
        base = 19'h31900;
        startLine(8'd50, 5'd12);
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (vramaddr == base + 19'd40) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("abort_reach_col40", {31'd0, found}, 32'd1);
        startLine(8'd60, 5'd14);
        checkOutput("abort_flushed", {31'd0, pix_valid}, 32'd0);
        tick();
        checkOutput("abort_first_addr", {13'd0, vramaddr}, 32'h39E00);
        runToEnd("abort", 19'h39E7F, ldb);

        // Underrun is sticky, line_start clears it, and reset overrides line_start.
        rd_auto = 1'b0;
        manual_rd = 1'b1; tick();
        manual_rd = 1'b0;
        checkOutput("underrun_set", {31'd0, underrun}, 32'd1);
        tick(); tick(); tick();
        checkOutput("underrun_held", {31'd0, underrun}, 32'd1);
        startLine(8'd70, 5'd0);
        checkOutput("underrun_cleared", {31'd0, underrun}, 32'd0);
        manual_rd = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        checkOutput("underrun_in_fetch", {31'd0, underrun}, 32'd1);
        rst = 1'b1; line_start = 1'b1; line_num = 8'd99;
        tick();
        rst = 1'b0; line_start = 1'b0;
        sb.delete();
        checkOutput("rst_vramaddr",  {13'd0, vramaddr}, 32'd0);
        checkOutput("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("rst_pix_data",  {24'd0, pix_data}, 32'd0);
        checkOutput("rst_underrun",  {31'd0, underrun}, 32'd0);
        checkOutput("rst_line_done", {31'd0, line_done}, 32'd0);
        manual_rd = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        checkOutput("rst_idle_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("rst_idle_addr", {13'd0, vramaddr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
